// File: rtl/mat3_pkg.sv
// Shared types and operand index map for the 3x3 matrix-vector stream driver.
package mat3_pkg;

    typedef enum logic [1:0] {LOAD, KICK, WAIT, DRAIN} state_t;

    localparam int N_OPERANDS = 12;
    localparam int N_RESULTS  = 3;

    // Byte order on the input stream: matrix row-major, then the vector.
    localparam int IDX_A11 = 0;
    localparam int IDX_A12 = 1;
    localparam int IDX_A13 = 2;
    localparam int IDX_A21 = 3;
    localparam int IDX_A22 = 4;
    localparam int IDX_A23 = 5;
    localparam int IDX_A31 = 6;
    localparam int IDX_A32 = 7;
    localparam int IDX_A33 = 8;
    localparam int IDX_X1  = 9;
    localparam int IDX_X2  = 10;
    localparam int IDX_X3  = 11;

endpackage

// File: rtl/mat3_result_serializer.sv
// Buffers the three accelerator results and emits them one word at a time
// on a valid/ready stream, flagging the last word.
module mat3_result_serializer
    import mat3_pkg::*;
#(
    parameter int RES_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [RES_W-1:0] y1,
    input  logic [RES_W-1:0] y2,
    input  logic [RES_W-1:0] y3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [RES_W-1:0] out_data,
    output logic             out_last,
    output logic             drain_done
);

    logic [RES_W-1:0] res_q [N_RESULTS];
    logic [1:0]       k_q;
    logic             vld_q;
    logic             fire;

    assign fire       = vld_q && out_ready;
    assign drain_done = fire && (k_q == 2'(N_RESULTS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_RESULTS; i++) res_q[i] <= '0;
            k_q   <= '0;
            vld_q <= 1'b0;
        end else if (load) begin
            res_q[0] <= y1;
            res_q[1] <= y2;
            res_q[2] <= y3;
            k_q      <= '0;
            vld_q    <= 1'b1;
        end else if (fire) begin
            if (drain_done) begin
                k_q   <= '0;
                vld_q <= 1'b0;
            end else begin
                k_q <= k_q + 2'd1;
            end
        end
    end

    assign out_valid = vld_q;
    assign out_data  = res_q[k_q];
    assign out_last  = vld_q && (k_q == 2'(N_RESULTS - 1));

endmodule

// File: rtl/mat3_stream_driver.sv
// Streams 12 operand bytes into the 3x3 accelerator, kicks it, and returns y1..y3.
// Optional WAIT timeout with sticky err is enabled by defining MAT3_DRV_TIMEOUT_EN.
module mat3_stream_driver
    import mat3_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] a11,
    output logic [DATA_W-1:0] a12,
    output logic [DATA_W-1:0] a13,
    output logic [DATA_W-1:0] a21,
    output logic [DATA_W-1:0] a22,
    output logic [DATA_W-1:0] a23,
    output logic [DATA_W-1:0] a31,
    output logic [DATA_W-1:0] a32,
    output logic [DATA_W-1:0] a33,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic              start,
    input  logic              acc_busy,
    input  logic              acc_done,
    input  logic [RES_W-1:0]  y1,
    input  logic [RES_W-1:0]  y2,
    input  logic [RES_W-1:0]  y3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic              out_last,
    output logic              err
);

    state_t            state_q, state_d;
    logic [3:0]        idx_q;
    logic [DATA_W-1:0] ops_q [N_OPERANDS];
    logic              in_ready_q;
    logic              in_fire;
    logic              capture;
    logic              zero_res;
    logic              timeout;
    logic              drain_done;

    assign in_ready = in_ready_q;
    assign in_fire  = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= LOAD;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        capture  = 1'b0;
        zero_res = 1'b0;
        case (state_q)
            LOAD:  if (in_fire && idx_q == 4'(IDX_X3)) state_d = KICK;
            KICK: begin
                if (!acc_busy) begin
                    start   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A real completion wins over a timeout landing in the same cycle.
                if (acc_done && !acc_busy) begin
                    capture = 1'b1;
                    state_d = DRAIN;
                end else if (timeout) begin
                    capture  = 1'b1;
                    zero_res = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: if (drain_done) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // in_ready is registered so it is low in reset and drops the cycle after the last byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) in_ready_q <= 1'b0;
        else          in_ready_q <= (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_OPERANDS; i++) ops_q[i] <= '0;
            idx_q <= '0;
        end else if (in_fire) begin
            ops_q[idx_q] <= in_data;
            idx_q        <= (idx_q == 4'(IDX_X3)) ? 4'd0 : idx_q + 4'd1;
        end
    end

    assign a11 = ops_q[IDX_A11];
    assign a12 = ops_q[IDX_A12];
    assign a13 = ops_q[IDX_A13];
    assign a21 = ops_q[IDX_A21];
    assign a22 = ops_q[IDX_A22];
    assign a23 = ops_q[IDX_A23];
    assign a31 = ops_q[IDX_A31];
    assign a32 = ops_q[IDX_A32];
    assign a33 = ops_q[IDX_A33];
    assign x1  = ops_q[IDX_X1];
    assign x2  = ops_q[IDX_X2];
    assign x3  = ops_q[IDX_X3];

`ifdef MAT3_DRV_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    assign timeout = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
            if (zero_res) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    mat3_result_serializer #(
        .RES_W (RES_W)
    ) u_ser (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (capture),
        .y1         (zero_res ? '0 : y1),
        .y2         (zero_res ? '0 : y2),
        .y3         (zero_res ? '0 : y3),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .drain_done (drain_done)
    );

endmodule

// File: tb/tb_mat3_stream_driver.sv
// Bench for mat3_stream_driver: directed frames, accelerator model, result scoreboard.
module tb_mat3_stream_driver;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  a11, a12, a13, a21, a22, a23, a31, a32, a33, x1, x2, x3;
    logic        start;
    logic        acc_busy;
    logic        acc_done;
    logic [15:0] y1, y2, y3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    mat3_stream_driver #(
        .DATA_W  (8),
        .RES_W   (16),
        .TIMEOUT (10)
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .a11 (a11), .a12 (a12), .a13 (a13),
        .a21 (a21), .a22 (a22), .a23 (a23),
        .a31 (a31), .a32 (a32), .a33 (a33),
        .x1 (x1), .x2 (x2), .x3 (x3),
        .start (start), .acc_busy (acc_busy), .acc_done (acc_done),
        .y1 (y1), .y2 (y2), .y3 (y3),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_data (out_data), .out_last (out_last),
        .err (err)
    );

    logic [7:0] ops_o [12];
    assign ops_o = '{a11, a12, a13, a21, a22, a23, a31, a32, a33, x1, x2, x3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mv(input logic [7:0] r0, r1, r2, v0, v1, v2);
        return 16'(32'(r0) * 32'(v0) + 32'(r1) * 32'(v1) + 32'(r2) * 32'(v2));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accelerator model: busy for two cycles after start, then a one-cycle done with A*x.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_y1 = '0, m_y2 = '0, m_y3 = '0;
    int          m_cnt = 0;
    int          model_mode = 0;
    logic        busy_force = 1'b0;

    assign acc_busy = m_busy | busy_force;
    assign acc_done = m_done;
    assign y1 = m_y1;
    assign y2 = m_y2;
    assign y3 = m_y3;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (m_cnt > 1) m_cnt <= m_cnt - 1;
        else if (m_cnt == 1) begin
            m_cnt  <= 0;
            m_busy <= 1'b0;
            if (model_mode == 0) begin
                m_done <= 1'b1;
                m_y1   <= mv(a11, a12, a13, x1, x2, x3);
                m_y2   <= mv(a21, a22, a23, x1, x2, x3);
                m_y3   <= mv(a31, a32, a33, x1, x2, x3);
            end
        end
        if (start) begin
            m_cnt  <= 2;
            m_busy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
            else begin
                mon_e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e.d));
                check("out_last", 32'(out_last), 32'(mon_e.l));
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int i = 0; i < 12; i++) check({tag, "_operand"}, 32'(ops_o[i]), 32'd0);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_expect(input logic [7:0] b [12], input bit zero);
        logic [15:0] e1, e2, e3;
        e1 = zero ? 16'd0 : mv(b[0], b[1], b[2], b[9], b[10], b[11]);
        e2 = zero ? 16'd0 : mv(b[3], b[4], b[5], b[9], b[10], b[11]);
        e3 = zero ? 16'd0 : mv(b[6], b[7], b[8], b[9], b[10], b[11]);
        sb.push_back('{d: e1, l: 1'b0});
        sb.push_back('{d: e2, l: 1'b0});
        sb.push_back('{d: e3, l: 1'b1});
    endtask

    task automatic send_frame(input logic [7:0] b [12], input bit zero);
        @(posedge clk);
        #1;
        push_expect(b, zero);
        for (int i = 0; i < 12; i++) send_byte(b[i]);
        for (int i = 0; i < 12; i++) check("operand", 32'(ops_o[i]), 32'(b[i]));
    endtask

    task automatic wait_start();
        int n = 0;
        @(negedge clk);
        while (!start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(start), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        int hi = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            if (in_ready) hi++;
            n++;
        end
        check("drain_complete", 32'(sb.size()), 32'd0);
        check("in_ready_low_until_drained", 32'(hi), 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] b [12]);
        send_frame(b, 1'b0);
        wait_start();
        @(negedge clk);
        check("start_width", 32'(start), 32'd0);
        check("in_ready_after_kick", 32'(in_ready), 32'd0);
        wait_drain();
    endtask

    logic [7:0] fr [12];
    int         n;
    int         bad;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset values, then reset mid-LOAD at idx=5 and a clean frame afterwards.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'(100 + i));
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_load");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fr = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
        run_frame(fr);

        // Identity matrix: words 3,4,5.
        fr = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd3, 8'd4, 8'd5};
        run_frame(fr);

        // All operands at maximum.
        for (int i = 0; i < 12; i++) fr[i] = 8'hFF;
        run_frame(fr);

        // Backpressure: out_ready low for 4 cycles while y2 is presented.
        fr = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd20, 8'd30, 8'd40};
        send_frame(fr, 1'b0);
        wait_start();
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'(sb[0].d));
            check("bp_hold_last", 32'(out_last), 32'd0);
            check("bp_queue_depth", 32'(sb.size()), 32'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Busy hold-off in KICK, then reset during WAIT.
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) send_byte(8'(i + 1));
        busy_force = 1'b1;
        send_byte(8'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_hold_start", 32'(start), 32'd0);
            @(posedge clk);
            #1;
        end
        busy_force = 1'b0;
        @(negedge clk);
        check("busy_release_start", 32'(start), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("wait_reset_out_valid", 32'(out_valid), 32'd0);
        check("wait_reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("no_output_after_reset", 32'(bad), 32'd0);
        check("back_in_load", 32'(in_ready), 32'd1);

`ifdef MAT3_DRV_TIMEOUT_EN
        // Accelerator never finishes: err after 10 WAIT cycles, three zero words.
        model_mode = 1;
        fr = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd1, 8'd1, 8'd1};
        send_frame(fr, 1'b1);
        wait_start();
        n = 0;
        while (!err && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd11);
        check("timeout_out_valid", 32'(out_valid), 32'd1);
        wait_drain();
        model_mode = 0;
        run_frame(fr);
        check("err_sticky", 32'(err), 32'd1);
`else
        check("err_tied_low", 32'(err), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
